// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: ALU operation codes, opcode/funct constants, decoded beat.
// Operation codes are what execute switches on; NOP is zero so a reset register decodes as NOP.
package decode_stage_pkg;

   typedef enum logic [7:0] {
      ALU_OPERATIONS_NOP = 8'd0,
      ALU_OPERATIONS_ADD, ALU_OPERATIONS_SUB, ALU_OPERATIONS_SLL, ALU_OPERATIONS_SLT,
      ALU_OPERATIONS_SLTU, ALU_OPERATIONS_XOR, ALU_OPERATIONS_SRL, ALU_OPERATIONS_SRA,
      ALU_OPERATIONS_OR, ALU_OPERATIONS_AND,
      ALU_OPERATIONS_MUL, ALU_OPERATIONS_MULH, ALU_OPERATIONS_MULSU, ALU_OPERATIONS_MULU,
      ALU_OPERATIONS_DIV, ALU_OPERATIONS_DIVU, ALU_OPERATIONS_REM, ALU_OPERATIONS_REMU,
      ALU_OPERATIONS_LB, ALU_OPERATIONS_LH, ALU_OPERATIONS_LW, ALU_OPERATIONS_LBU, ALU_OPERATIONS_LHU,
      ALU_OPERATIONS_SB, ALU_OPERATIONS_SH, ALU_OPERATIONS_SW,
      ALU_OPERATIONS_BEQ, ALU_OPERATIONS_BNE, ALU_OPERATIONS_BLT, ALU_OPERATIONS_BGE,
      ALU_OPERATIONS_BLTU, ALU_OPERATIONS_BGEU,
      ALU_OPERATIONS_JAL, ALU_OPERATIONS_JALR, ALU_OPERATIONS_LUI, ALU_OPERATIONS_AUIPC
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      alu_op_e     op;
      logic [31:0] operand1;
      logic [31:0] operand2;
      logic [31:0] imm;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        is_branch;
      logic        illegal;
   } dec_t;

   function automatic alu_op_e base_op(input logic [2:0] f3);
      case (f3)
         3'd0:    return ALU_OPERATIONS_ADD;
         3'd1:    return ALU_OPERATIONS_SLL;
         3'd2:    return ALU_OPERATIONS_SLT;
         3'd3:    return ALU_OPERATIONS_SLTU;
         3'd4:    return ALU_OPERATIONS_XOR;
         3'd5:    return ALU_OPERATIONS_SRL;
         3'd6:    return ALU_OPERATIONS_OR;
         default: return ALU_OPERATIONS_AND;
      endcase
   endfunction

   function automatic alu_op_e muldiv_op(input logic [2:0] f3);
      case (f3)
         3'd0:    return ALU_OPERATIONS_MUL;
         3'd1:    return ALU_OPERATIONS_MULH;
         3'd2:    return ALU_OPERATIONS_MULSU;
         3'd3:    return ALU_OPERATIONS_MULU;
         3'd4:    return ALU_OPERATIONS_DIV;
         3'd5:    return ALU_OPERATIONS_DIVU;
         3'd6:    return ALU_OPERATIONS_REM;
         default: return ALU_OPERATIONS_REMU;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode request bus and decode->execute ID/EX bus, each a valid/ready handshake.
interface fetch_dec_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;

   modport master (output in_valid, in_pc, in_instr, input in_ready);
   modport slave  (input in_valid, in_pc, in_instr, output in_ready);
endinterface

interface dec_ex_if;
   import decode_stage_pkg::*;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc;
   alu_op_e     alu_operation;
   logic        is_branch_instruction;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic [31:0] imm;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        illegal;

   modport master (output out_valid, pc, alu_operation, is_branch_instruction, operand1, operand2,
                          imm, store_data, rd, reg_write, mem_read, mem_write, illegal,
                   input  out_ready);
   modport slave  (input  out_valid, pc, alu_operation, is_branch_instruction, operand1, operand2,
                          imm, store_data, rd, reg_write, mem_read, mem_write, illegal,
                   output out_ready);
endinterface

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I(M) classifier: instruction word plus register data -> decoded beat.
// Illegal encodings are squashed to a NOP with all side-effect controls cleared.
module instr_decoder
   import decode_stage_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output dec_t        dec
);

   logic [6:0]  opcode;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
   logic        writes;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};

   always_comb begin
      dec          = '0;
      dec.op       = ALU_OPERATIONS_NOP;
      dec.operand1 = rs1_data;
      dec.operand2 = rs2_data;
      dec.rd       = instr[11:7];
      writes       = 1'b0;
      case (opcode)
         OPC_OP: begin
            writes = 1'b1;
            if (f7 == F7_BASE)                     dec.op = base_op(f3);
            else if (f7 == F7_ALT && f3 == 3'd0)   dec.op = ALU_OPERATIONS_SUB;
            else if (f7 == F7_ALT && f3 == 3'd5)   dec.op = ALU_OPERATIONS_SRA;
            else if (f7 == F7_MULDIV && ENABLE_M)  dec.op = muldiv_op(f3);
            else                                   dec.illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            writes       = 1'b1;
            dec.operand2 = imm_i;
            dec.imm      = imm_i;
            // Only the shifts constrain funct7; elsewhere those bits are immediate.
            if (f3 == 3'd1)      dec.illegal = (f7 != F7_BASE);
            if (f3 == 3'd5 && f7 == F7_ALT) dec.op = ALU_OPERATIONS_SRA;
            else if (f3 == 3'd5) begin
               dec.op      = ALU_OPERATIONS_SRL;
               dec.illegal = (f7 != F7_BASE);
            end else         dec.op = base_op(f3);
         end
         OPC_LOAD: begin
            writes       = 1'b1;
            dec.mem_read = 1'b1;
            dec.operand2 = imm_i;
            dec.imm      = imm_i;
            case (f3)
               3'd0:    dec.op = ALU_OPERATIONS_LB;
               3'd1:    dec.op = ALU_OPERATIONS_LH;
               3'd2:    dec.op = ALU_OPERATIONS_LW;
               3'd4:    dec.op = ALU_OPERATIONS_LBU;
               3'd5:    dec.op = ALU_OPERATIONS_LHU;
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_STORE: begin
            dec.mem_write  = 1'b1;
            dec.operand2   = imm_s;
            dec.imm        = imm_s;
            dec.store_data = rs2_data;
            case (f3)
               3'd0:    dec.op = ALU_OPERATIONS_SB;
               3'd1:    dec.op = ALU_OPERATIONS_SH;
               3'd2:    dec.op = ALU_OPERATIONS_SW;
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_BRANCH: begin
            dec.is_branch = 1'b1;
            dec.imm       = imm_b;
            case (f3)
               3'd0:    dec.op = ALU_OPERATIONS_BEQ;
               3'd1:    dec.op = ALU_OPERATIONS_BNE;
               3'd4:    dec.op = ALU_OPERATIONS_BLT;
               3'd5:    dec.op = ALU_OPERATIONS_BGE;
               3'd6:    dec.op = ALU_OPERATIONS_BLTU;
               3'd7:    dec.op = ALU_OPERATIONS_BGEU;
               default: dec.illegal = 1'b1;
            endcase
         end
         OPC_JAL: begin
            writes       = 1'b1;
            dec.op       = ALU_OPERATIONS_JAL;
            dec.operand1 = '0;
            dec.operand2 = imm_j;
            dec.imm      = imm_j;
         end
         OPC_JALR: begin
            writes       = 1'b1;
            dec.op       = ALU_OPERATIONS_JALR;
            dec.operand2 = imm_i;
            dec.imm      = imm_i;
            dec.illegal  = (f3 != 3'd0);
         end
         OPC_LUI, OPC_AUIPC: begin
            writes       = 1'b1;
            dec.op       = (opcode == OPC_LUI) ? ALU_OPERATIONS_LUI : ALU_OPERATIONS_AUIPC;
            dec.operand1 = '0;
            dec.operand2 = {12'b0, instr[31:12]};
            dec.imm      = imm_u;
         end
         default: dec.illegal = 1'b1;
      endcase

      dec.reg_write = writes && !dec.illegal && (dec.rd != 5'd0);
      if (dec.illegal) begin
         dec.op        = ALU_OPERATIONS_NOP;
         dec.mem_read  = 1'b0;
         dec.mem_write = 1'b0;
         dec.is_branch = 1'b0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32IM decode stage: regfile read, instruction classification and the ID/EX register.
// One-cycle latency, one beat per cycle; a redirect flush empties the register and drops the incoming beat.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   fetch_dec_if.slave  fetch,
   dec_ex_if.master    ex,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        flush
);

   dec_t        dec;
   dec_t        q;
   logic [31:0] pc_q;
   logic        vld;
   logic        accept;

   assign rs1_addr       = fetch.in_instr[19:15];
   assign rs2_addr       = fetch.in_instr[24:20];
   assign fetch.in_ready = flush || !vld || ex.out_ready;
   assign accept         = fetch.in_valid && fetch.in_ready && !flush;

   instr_decoder #(.ENABLE_M(ENABLE_M)) u_instr_decoder (
      .instr    (fetch.in_instr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .dec      (dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         pc_q <= '0;
         q    <= '0;
      end else begin
         if (flush)             vld <= 1'b0;
         else if (accept)       vld <= 1'b1;
         else if (ex.out_ready) vld <= 1'b0;
         if (accept) begin
            q    <= dec;
            pc_q <= fetch.in_pc;
         end
      end
   end

   assign ex.out_valid             = vld;
   assign ex.pc                    = pc_q;
   assign ex.alu_operation         = q.op;
   assign ex.is_branch_instruction = q.is_branch;
   assign ex.operand1              = q.operand1;
   assign ex.operand2              = q.operand2;
   assign ex.imm                   = q.imm;
   assign ex.store_data            = q.store_data;
   assign ex.rd                    = q.rd;
   assign ex.reg_write             = q.reg_write;
   assign ex.mem_read              = q.mem_read;
   assign ex.mem_write             = q.mem_write;
   assign ex.illegal               = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed ISA cases, async reset, then random traffic against a table-driven model.
module tb_decode_stage;
   import decode_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] regs [32];
   logic [4:0]  rs1_addr, rs2_addr, rs1_addr_nm, rs2_addr_nm;
   logic [31:0] rs1_data, rs2_data, rs1_data_nm, rs2_data_nm;

   always #5 clk = ~clk;

   fetch_dec_if fi();
   dec_ex_if    ex();
   fetch_dec_if fi_nm();
   dec_ex_if    ex_nm();

   assign rs1_data    = regs[rs1_addr];
   assign rs2_data    = regs[rs2_addr];
   assign rs1_data_nm = regs[rs1_addr_nm];
   assign rs2_data_nm = regs[rs2_addr_nm];
   assign fi_nm.in_valid  = fi.in_valid;
   assign fi_nm.in_pc     = fi.in_pc;
   assign fi_nm.in_instr  = fi.in_instr;
   assign ex_nm.out_ready = ex.out_ready;

   decode_stage #(.ENABLE_M(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .fetch(fi), .ex(ex),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush)
   );

   decode_stage #(.ENABLE_M(1'b0)) dut_nm (
      .clk(clk), .rst_n(rst_n), .fetch(fi_nm), .ex(ex_nm),
      .rs1_addr(rs1_addr_nm), .rs2_addr(rs2_addr_nm),
      .rs1_data(rs1_data_nm), .rs2_data(rs2_data_nm), .flush(flush)
   );

   typedef struct {
      alu_op_e     op;
      logic [31:0] o1, o2, imm, sd;
      logic [4:0]  rd;
      bit          rw, mr, mw, br, ill;
   } beat_t;

   int tests = 0;
   int fails = 0;

   bit          exp_valid;
   beat_t       exp_b, exp_nm;
   logic [31:0] exp_pc, pc_ctr;

   alu_op_e base_tbl [8] = '{ALU_OPERATIONS_ADD, ALU_OPERATIONS_SLL, ALU_OPERATIONS_SLT, ALU_OPERATIONS_SLTU,
                             ALU_OPERATIONS_XOR, ALU_OPERATIONS_SRL, ALU_OPERATIONS_OR, ALU_OPERATIONS_AND};
   alu_op_e md_tbl [8]   = '{ALU_OPERATIONS_MUL, ALU_OPERATIONS_MULH, ALU_OPERATIONS_MULSU, ALU_OPERATIONS_MULU,
                             ALU_OPERATIONS_DIV, ALU_OPERATIONS_DIVU, ALU_OPERATIONS_REM, ALU_OPERATIONS_REMU};
   alu_op_e ld_tbl [8]   = '{ALU_OPERATIONS_LB, ALU_OPERATIONS_LH, ALU_OPERATIONS_LW, ALU_OPERATIONS_NOP,
                             ALU_OPERATIONS_LBU, ALU_OPERATIONS_LHU, ALU_OPERATIONS_NOP, ALU_OPERATIONS_NOP};
   alu_op_e st_tbl [8]   = '{ALU_OPERATIONS_SB, ALU_OPERATIONS_SH, ALU_OPERATIONS_SW, ALU_OPERATIONS_NOP,
                             ALU_OPERATIONS_NOP, ALU_OPERATIONS_NOP, ALU_OPERATIONS_NOP, ALU_OPERATIONS_NOP};
   alu_op_e br_tbl [8]   = '{ALU_OPERATIONS_BEQ, ALU_OPERATIONS_BNE, ALU_OPERATIONS_NOP, ALU_OPERATIONS_NOP,
                             ALU_OPERATIONS_BLT, ALU_OPERATIONS_BGE, ALU_OPERATIONS_BLTU, ALU_OPERATIONS_BGEU};
   logic [6:0] opc_tbl [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic beat_t model_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                          input bit en_m);
      beat_t       e;
      int          f3;
      logic [6:0]  f7;
      logic [31:0] ii, is, ib, ij;
      bit          writes;
      f3 = int'(ins[14:12]);
      f7 = ins[31:25];
      ii = 32'($signed(ins[31:20]));
      is = 32'($signed({ins[31:25], ins[11:7]}));
      ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      e = '{op: ALU_OPERATIONS_NOP, o1: a, o2: b, imm: 32'd0, sd: 32'd0, rd: ins[11:7],
            rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, ill: 1'b0};
      writes = 1'b0;
      case (ins[6:0])
         7'h33: begin
            writes = 1'b1;
            if (f7 == 7'h00)                   e.op = base_tbl[f3];
            else if (f7 == 7'h20 && f3 == 0)   e.op = ALU_OPERATIONS_SUB;
            else if (f7 == 7'h20 && f3 == 5)   e.op = ALU_OPERATIONS_SRA;
            else if (f7 == 7'h01 && en_m)      e.op = md_tbl[f3];
            else                               e.ill = 1'b1;
         end
         7'h13: begin
            writes = 1'b1; e.o2 = ii; e.imm = ii;
            if (f3 == 1 && f7 != 7'h00)        e.ill = 1'b1;
            else if (f3 == 5 && f7 == 7'h20)   e.op = ALU_OPERATIONS_SRA;
            else if (f3 == 5 && f7 != 7'h00)   e.ill = 1'b1;
            else                               e.op = base_tbl[f3];
         end
         7'h03: begin
            writes = 1'b1; e.mr = 1'b1; e.o2 = ii; e.imm = ii;
            e.op = ld_tbl[f3]; e.ill = (e.op == ALU_OPERATIONS_NOP);
         end
         7'h23: begin
            e.mw = 1'b1; e.o2 = is; e.imm = is; e.sd = b;
            e.op = st_tbl[f3]; e.ill = (e.op == ALU_OPERATIONS_NOP);
         end
         7'h63: begin
            e.br = 1'b1; e.imm = ib;
            e.op = br_tbl[f3]; e.ill = (e.op == ALU_OPERATIONS_NOP);
         end
         7'h6F: begin writes = 1'b1; e.op = ALU_OPERATIONS_JAL; e.o1 = 0; e.o2 = ij; e.imm = ij; end
         7'h67: begin
            writes = 1'b1; e.op = ALU_OPERATIONS_JALR; e.o2 = ii; e.imm = ii; e.ill = (f3 != 0);
         end
         7'h37, 7'h17: begin
            writes = 1'b1;
            e.op   = (ins[6:0] == 7'h37) ? ALU_OPERATIONS_LUI : ALU_OPERATIONS_AUIPC;
            e.o1   = 0; e.o2 = ins >> 12; e.imm = ins & 32'hFFFF_F000;
         end
         default: e.ill = 1'b1;
      endcase
      e.rw = writes && !e.ill && (ins[11:7] != 0);
      if (e.ill) begin
         e.op = ALU_OPERATIONS_NOP; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] ins;
      int          sel;
      ins = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 9) ins[6:0] = opc_tbl[sel];
      case ($urandom_range(0, 3))
         0: ins[31:25] = 7'h00;
         1: ins[31:25] = 7'h20;
         2: ins[31:25] = 7'h01;
         default: ;
      endcase
      return ins;
   endfunction

   task automatic check_out();
      chk_eq("out_valid", ex.out_valid, exp_valid);
      chk_eq("out_valid_nm", ex_nm.out_valid, exp_valid);
      if (exp_valid) begin
         chk_eq("pc", ex.pc, exp_pc);
         chk_eq("op", ex.alu_operation, exp_b.op);
         chk_eq("illegal", ex.illegal, exp_b.ill);
         chk_eq("reg_write", ex.reg_write, exp_b.rw);
         chk_eq("mem_read", ex.mem_read, exp_b.mr);
         chk_eq("mem_write", ex.mem_write, exp_b.mw);
         chk_eq("is_branch", ex.is_branch_instruction, exp_b.br);
         chk_eq("op_nm", ex_nm.alu_operation, exp_nm.op);
         chk_eq("illegal_nm", ex_nm.illegal, exp_nm.ill);
         chk_eq("reg_write_nm", ex_nm.reg_write, exp_nm.rw);
         if (!exp_b.ill) begin
            chk_eq("operand1", ex.operand1, exp_b.o1);
            chk_eq("operand2", ex.operand2, exp_b.o2);
            chk_eq("imm", ex.imm, exp_b.imm);
            chk_eq("store_data", ex.store_data, exp_b.sd);
            chk_eq("rd", ex.rd, exp_b.rd);
         end
      end
   endtask

   task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
      bit exp_rdy;
      @(negedge clk);
      fi.in_valid  = v;
      fi.in_instr  = ins;
      fi.in_pc     = pc_ctr;
      ex.out_ready = ordy;
      flush        = fl;
      #1;
      exp_rdy = fl || !exp_valid || ordy;
      chk_eq("in_ready", fi.in_ready, exp_rdy);
      chk_eq("in_ready_nm", fi_nm.in_ready, exp_rdy);
      chk_eq("rs1_addr", rs1_addr, ins[19:15]);
      chk_eq("rs2_addr_nm", rs2_addr_nm, ins[24:20]);
      chk_eq("rs1_addr_nm", rs1_addr_nm, ins[19:15]);
      chk_eq("rs2_addr", rs2_addr, ins[24:20]);
      if (fl) exp_valid = 1'b0;
      else if (v && exp_rdy) begin
         exp_valid = 1'b1;
         exp_b     = model_decode(ins, regs[ins[19:15]], regs[ins[24:20]], 1'b1);
         exp_nm    = model_decode(ins, regs[ins[19:15]], regs[ins[24:20]], 1'b0);
         exp_pc    = pc_ctr;
      end else if (ordy) exp_valid = 1'b0;
      if (v && exp_rdy) pc_ctr += 32'd4;
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      regs[0]      = '0;
      fi.in_valid  = 1'b0;
      fi.in_instr  = '0;
      fi.in_pc     = '0;
      ex.out_ready = 1'b0;
      exp_valid    = 1'b0;
      pc_ctr       = 32'h0000_1000;

      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_out_valid", ex.out_valid, 1'b0);
      chk_eq("rst_op", ex.alu_operation, ALU_OPERATIONS_NOP);
      chk_eq("rst_pc", ex.pc, 32'd0);
      chk_eq("rst_operand2", ex.operand2, 32'd0);
      chk_eq("rst_reg_write", ex.reg_write, 1'b0);
      chk_eq("rst_out_valid_nm", ex_nm.out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      regs[1] = 32'd5;
      regs[2] = 32'd7;
      step(1'b1, 32'h002081B3, 1'b1, 1'b0);
      chk_eq("add_valid", ex.out_valid, 1'b1);
      chk_eq("add_op", ex.alu_operation, ALU_OPERATIONS_ADD);
      chk_eq("add_operand1", ex.operand1, 32'd5);
      chk_eq("add_operand2", ex.operand2, 32'd7);
      chk_eq("add_rd", ex.rd, 32'd3);
      chk_eq("add_reg_write", ex.reg_write, 1'b1);

      step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
      chk_eq("addi_op", ex.alu_operation, ALU_OPERATIONS_ADD);
      chk_eq("addi_operand2", ex.operand2, 32'hFFFF_FFFF);

      step(1'b1, 32'h123452B7, 1'b1, 1'b0);
      chk_eq("lui_op", ex.alu_operation, ALU_OPERATIONS_LUI);
      chk_eq("lui_operand2", ex.operand2, 32'h0001_2345);

      regs[2] = 32'h0000_CAFE;
      step(1'b1, 32'h0020A423, 1'b1, 1'b0);
      chk_eq("sw_op", ex.alu_operation, ALU_OPERATIONS_SW);
      chk_eq("sw_operand2", ex.operand2, 32'd8);
      chk_eq("sw_store_data", ex.store_data, 32'h0000_CAFE);
      chk_eq("sw_mem_write", ex.mem_write, 1'b1);
      chk_eq("sw_reg_write", ex.reg_write, 1'b0);

      // Stall execute for three cycles while fetch keeps offering a new beat.
      repeat (3) begin
         step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
         chk_eq("hold_op", ex.alu_operation, ALU_OPERATIONS_SW);
         chk_eq("hold_store_data", ex.store_data, 32'h0000_CAFE);
         chk_eq("hold_in_ready", fi.in_ready, 1'b0);
      end
      step(1'b1, 32'h002081B3, 1'b1, 1'b0);
      chk_eq("release_valid", ex.out_valid, 1'b1);
      chk_eq("release_op", ex.alu_operation, ALU_OPERATIONS_ADD);

      step(1'b1, 32'hFFF00093, 1'b1, 1'b1);
      chk_eq("flush_valid", ex.out_valid, 1'b0);

      step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      chk_eq("illegal_flag", ex.illegal, 1'b1);
      chk_eq("illegal_op", ex.alu_operation, ALU_OPERATIONS_NOP);
      chk_eq("illegal_reg_write", ex.reg_write, 1'b0);
      chk_eq("illegal_valid", ex.out_valid, 1'b1);

      step(1'b1, 32'h022081B3, 1'b1, 1'b0);
      chk_eq("mul_op", ex.alu_operation, ALU_OPERATIONS_MUL);
      chk_eq("mul_nm_illegal", ex_nm.illegal, 1'b1);
      chk_eq("mul_nm_op", ex_nm.alu_operation, ALU_OPERATIONS_NOP);

      step(1'b1, 32'h002081B3, 1'b1, 1'b0);
      step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("arst_out_valid", ex.out_valid, 1'b0);
      chk_eq("arst_op", ex.alu_operation, ALU_OPERATIONS_NOP);
      chk_eq("arst_pc", ex.pc, 32'd0);
      exp_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 19) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
